// File: rtl/gtx_clock_sequencer.sv
// GTX bring-up sequencer: CPLL reset, lock wait with retries, settle, GT reset, user-ready handoff.
// Optional lock-loss event counter enabled by defining GTX_CLK_SEQ_LOSS_CNT_EN.
module gtx_clock_sequencer #(
    parameter int CH_NUM         = 1,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 60000,
    parameter int SETTLE_CYCLES  = 256,
    parameter int GT_RST_CYCLES  = 16,
    parameter int MAX_RETRY      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic [CH_NUM-1:0] cplllock,
    input  logic [CH_NUM-1:0] txresetdone,
    input  logic [CH_NUM-1:0] rxresetdone,
    output logic [CH_NUM-1:0] cpllreset,
    output logic [CH_NUM-1:0] gttxreset,
    output logic [CH_NUM-1:0] gtrxreset,
    output logic [CH_NUM-1:0] userrdy,
    output logic              clk_ready,
    output logic              fault,
    output logic [2:0]        state,
    output logic [7:0]        lock_loss_cnt
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT), max2(SETTLE_CYCLES, GT_RST_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        SETTLE    = 3'd3,
        GT_RST    = 3'd4,
        WAIT_DONE = 3'd5,
        READY     = 3'd6,
        FAULT     = 3'd7
    } state_t;

    state_t             cur, nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]         retry, retry_nxt;
    logic [CH_NUM-1:0]  lock_s1, lock_s2, txd_s1, txd_s2, rxd_s1, rxd_s2;
    logic               all_lock, all_done;

    assign all_lock = &lock_s2;
    assign all_done = (&txd_s2) & (&rxd_s2);
    assign state    = cur;

    always_comb begin
        nxt       = cur;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        if (restart) begin
            nxt       = PLL_RST;
            retry_nxt = '0;
        end else begin
            case (cur)
                IDLE: nxt = PLL_RST;
                PLL_RST: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (all_lock) begin
                        nxt = SETTLE;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        retry_nxt = retry + 4'd1;
                        nxt = (retry == 4'(MAX_RETRY - 1)) ? FAULT : PLL_RST;
                    end
                end
                // Any lock drop once past WAIT_LOCK restarts from the CPLL reset.
                SETTLE: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (!all_lock)                                nxt = PLL_RST;
                    else if (cnt == CNT_W'(SETTLE_CYCLES - 1))    nxt = GT_RST;
                end
                GT_RST: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (!all_lock)                                nxt = PLL_RST;
                    else if (cnt == CNT_W'(GT_RST_CYCLES - 1))    nxt = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!all_lock)      nxt = PLL_RST;
                    else if (all_done)  nxt = READY;
                end
                READY: begin
                    if (!all_lock) nxt = PLL_RST;
                end
                default: nxt = FAULT;
            endcase
            if (nxt == READY && cur != READY) retry_nxt = '0;
        end
        // Restart while already in PLL_RST must still give a full-width pulse.
        if (nxt != cur || restart) cnt_nxt = '0;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= IDLE;
            cnt       <= '0;
            retry     <= '0;
            lock_s1   <= '0;
            lock_s2   <= '0;
            txd_s1    <= '0;
            txd_s2    <= '0;
            rxd_s1    <= '0;
            rxd_s2    <= '0;
            cpllreset <= '1;
            gttxreset <= '1;
            gtrxreset <= '1;
            userrdy   <= '0;
            clk_ready <= 1'b0;
            fault     <= 1'b0;
        end else begin
            cur       <= nxt;
            cnt       <= cnt_nxt;
            retry     <= retry_nxt;
            lock_s1   <= cplllock;
            lock_s2   <= lock_s1;
            txd_s1    <= txresetdone;
            txd_s2    <= txd_s1;
            rxd_s1    <= rxresetdone;
            rxd_s2    <= rxd_s1;
            cpllreset <= {CH_NUM{nxt == IDLE || nxt == PLL_RST || nxt == FAULT}};
            gttxreset <= {CH_NUM{nxt == IDLE || nxt == PLL_RST || nxt == GT_RST}};
            gtrxreset <= {CH_NUM{nxt == IDLE || nxt == PLL_RST || nxt == GT_RST}};
            userrdy   <= {CH_NUM{nxt == WAIT_DONE || nxt == READY}};
            clk_ready <= (nxt == READY);
            fault     <= (nxt == FAULT);
        end
    end

`ifdef GTX_CLK_SEQ_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_cnt;

    assign loss_evt = !restart && !all_lock &&
                      (cur == SETTLE || cur == GT_RST || cur == WAIT_DONE || cur == READY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               loss_cnt <= '0;
        else if (loss_evt && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end

    assign lock_loss_cnt = loss_cnt;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_gtx_clock_sequencer.sv
// Directed bench for gtx_clock_sequencer with CH_NUM=2 and shortened timing parameters.
module tb_gtx_clock_sequencer;

`ifdef GTX_CLK_SEQ_LOSS_CNT_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, restart;
    logic [1:0] cplllock, txresetdone, rxresetdone;
    logic [1:0] cpllreset, gttxreset, gtrxreset, userrdy;
    logic       clk_ready, fault;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;

    gtx_clock_sequencer #(
        .CH_NUM(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(100),
        .SETTLE_CYCLES(8), .GT_RST_CYCLES(4), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .cplllock(cplllock), .txresetdone(txresetdone), .rxresetdone(rxresetdone),
        .cpllreset(cpllreset), .gttxreset(gttxreset), .gtrxreset(gtrxreset),
        .userrdy(userrdy), .clk_ready(clk_ready), .fault(fault),
        .state(state), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] cpll;
        logic [1:0] gttx;
        logic [1:0] ur;
        logic       cr;
    } smp_t;

    smp_t trace[$];
    int   run_st[$];
    int   run_len[$];

    always @(negedge clk) trace.push_back({state, cpllreset, gttxreset, userrdy, clk_ready});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string tag);
        int n = 0;
        while (state !== s && n < max) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        trace.delete();
    endtask

    task automatic build_runs();
        run_st.delete();
        run_len.delete();
        foreach (trace[i]) begin
            if (run_st.size() == 0 || run_st[run_st.size()-1] != int'(trace[i].st)) begin
                run_st.push_back(int'(trace[i].st));
                run_len.push_back(1);
            end else begin
                run_len[run_len.size()-1] += 1;
            end
        end
    endtask

    function automatic int count_runs(input int s);
        int n = 0;
        foreach (run_st[i]) if (run_st[i] == s) n++;
        return n;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},  32'(state),         32'd0);
        check({tag, "_cpll"},   32'(cpllreset),     32'd3);
        check({tag, "_gttx"},   32'(gttxreset),     32'd3);
        check({tag, "_gtrx"},   32'(gtrxreset),     32'd3);
        check({tag, "_urdy"},   32'(userrdy),       32'd0);
        check({tag, "_ready"},  32'(clk_ready),     32'd0);
        check({tag, "_fault"},  32'(fault),         32'd0);
        check({tag, "_llc"},    32'(lock_loss_cnt), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; restart = 1'b0;
        cplllock = 2'b00; txresetdone = 2'b00; rxresetdone = 2'b00;
        tick(); tick();
        check_reset_vals("rst0");

        // Nominal bring-up: lock 10 cycles into WAIT_LOCK, done 5 cycles after GT_RST.
        do_reset();
        wait_state(3'd2, 20, "t1_wl");
        repeat (10) tick();
        cplllock = 2'b11;
        wait_state(3'd5, 40, "t1_wd");
        repeat (5) tick();
        txresetdone = 2'b11; rxresetdone = 2'b11;
        wait_state(3'd6, 20, "t1_rdy");
        tick();
        build_runs();
        check("t1_r0_st", 32'(run_st[0]), 0);  check("t1_r0_len", 32'(run_len[0]), 1);
        check("t1_r1_st", 32'(run_st[1]), 1);  check("t1_r1_len", 32'(run_len[1]), 4);
        check("t1_r2_st", 32'(run_st[2]), 2);  check("t1_r2_len", 32'(run_len[2]), 13);
        check("t1_r3_st", 32'(run_st[3]), 3);  check("t1_r3_len", 32'(run_len[3]), 8);
        check("t1_r4_st", 32'(run_st[4]), 4);  check("t1_r4_len", 32'(run_len[4]), 4);
        check("t1_r5_st", 32'(run_st[5]), 5);  check("t1_r5_len", 32'(run_len[5]), 8);
        check("t1_r6_st", 32'(run_st[6]), 6);
        n = 0;
        foreach (trace[i]) if (trace[i].st != 3'd0 && trace[i].cpll == 2'b11) n++;
        check("t1_cpll_hi", 32'(n), 4);
        n = 0;
        foreach (trace[i]) if (trace[i].st == 3'd4 && trace[i].gttx == 2'b11) n++;
        check("t1_gttx_hi", 32'(n), 4);
        n = 0;
        foreach (trace[i]) if (trace[i].st == 3'd5 && trace[i].gttx != 2'b00) n++;
        check("t1_gttx_wd", 32'(n), 0);
        check("t1_ready", 32'(clk_ready), 1);
        check("t1_urdy", 32'(userrdy), 3);

        // Lock timeouts to FAULT, then restart.
        cplllock = 2'b01; txresetdone = 2'b00; rxresetdone = 2'b00;
        do_reset();
        wait_state(3'd7, 500, "t2_fault_st");
        tick();
        build_runs();
        check("t2_wl1_len", 32'(run_len[2]), 100);
        check("t2_r3_st",   32'(run_st[3]), 1);
        check("t2_wl2_len", 32'(run_len[4]), 100);
        check("t2_wl3_len", 32'(run_len[6]), 100);
        check("t2_r7_st",   32'(run_st[7]), 7);
        check("t2_fault",   32'(fault), 1);
        check("t2_cpll",    32'(cpllreset), 3);
        trace.delete();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("t2_rs_st",    32'(state), 1);
        check("t2_rs_fault", 32'(fault), 0);
        wait_state(3'd7, 500, "t2_fault2_st");
        build_runs();
        check("t2_retry_clr", 32'(count_runs(2)), 3);

        // One-cycle lock glitch at SETTLE count 5.
        cplllock = 2'b11; txresetdone = 2'b11; rxresetdone = 2'b11;
        do_reset();
        wait_state(3'd3, 30, "t3_settle");
        repeat (3) tick();
        cplllock = 2'b10;
        tick();
        cplllock = 2'b11;
        wait_state(3'd1, 10, "t3_back");
        tick();
        build_runs();
        check("t3_r2_len", 32'(run_len[2]), 1);
        check("t3_r3_st",  32'(run_st[3]), 3);
        check("t3_r3_len", 32'(run_len[3]), 6);
        check("t3_r4_st",  32'(run_st[4]), 1);
        check("t3_no_gt",  32'(count_runs(4)), 0);
        check("t3_llc",    32'(lock_loss_cnt), LC_EN ? 32'd1 : 32'd0);
        wait_state(3'd6, 100, "t3_rdy");

        // Lock loss in READY and counter saturation.
        do_reset();
        wait_state(3'd6, 100, "t4_rdy");
        check("t4_ready0", 32'(clk_ready), 1);
        check("t4_llc0",   32'(lock_loss_cnt), 0);
        cplllock = 2'b00;
        tick(); tick();
        check("t4_hold_st",  32'(state), 6);
        check("t4_hold_rdy", 32'(clk_ready), 1);
        tick();
        check("t4_loss_st",  32'(state), 1);
        check("t4_loss_rdy", 32'(clk_ready), 0);
        check("t4_loss_ur",  32'(userrdy), 0);
        check("t4_llc1",     32'(lock_loss_cnt), LC_EN ? 32'd1 : 32'd0);
        for (int i = 0; i < 299; i++) begin
            cplllock = 2'b11;
            wait_state(3'd6, 100, "t4_loop_rdy");
            cplllock = 2'b00;
            wait_state(3'd1, 10, "t4_loop_loss");
        end
        check("t4_llc_sat", 32'(lock_loss_cnt), LC_EN ? 32'd255 : 32'd0);

        // Async reset during GT_RST, then full rerun.
        cplllock = 2'b11; txresetdone = 2'b00; rxresetdone = 2'b00;
        do_reset();
        wait_state(3'd4, 30, "t5_gtrst");
        tick();
        rst = 1'b1;
        #1;
        check_reset_vals("t5_async");
        do_reset();
        wait_state(3'd5, 40, "t5_wd");
        txresetdone = 2'b11; rxresetdone = 2'b11;
        wait_state(3'd6, 20, "t5_rdy");
        tick();
        build_runs();
        for (int i = 0; i < 7; i++) check("t5_seq", 32'(run_st[i]), 32'(i));
        check("t5_ready", 32'(clk_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
